btn_sw_debounce: RTL



---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_chan.sv | 88 ++++++++
 rtl/btn_sw_debounce.sv | 92 +++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and types for the button/switch input conditioner.
package debounce_pkg;

  localparam int N_BTN = 5;
  localparam int N_SW  = 8;

  // Debounce windows: short one for simulation, 10 ms at 100 MHz for the board build
  localparam int DEB_CYCLES_SIM   = 4;
  localparam int DEB_CYCLES_BOARD = 1_000_000;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One input line: 2-flop synchroniser, stability counter and level FSM
// with registered level plus one-cycle rise/fall pulses.
//
//   state     | meaning
//   LOW       | accepted level 0, synchronised input also 0
//   WAIT_HIGH | accepted level 0, input has been 1 for cnt cycles
//   HIGH      | accepted level 1, synchronised input also 1
//   WAIT_LOW  | accepted level 1, input has been 0 for cnt cycles
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100
) (
  input  logic sys_clk_in,
  input  logic sys_rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          s1, s2;
  deb_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Entering a wait state counts the first stable cycle; the counter holds at max.
  always_comb begin
    cnt_nxt = cnt;
    if (state == LOW || state == HIGH) cnt_nxt = CW'(1);
    else if (cnt != CNT_MAX)           cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= pin;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        LOW, WAIT_HIGH: begin
          if (!s2) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt_nxt == CNT_MAX) begin
            state <= HIGH;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b1;
          end else begin
            state <= WAIT_HIGH;
            cnt   <= cnt_nxt;
          end
        end
        HIGH, WAIT_LOW: begin
          if (s2) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt_nxt == CNT_MAX) begin
            state <= LOW;
            cnt   <= '0;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            state <= WAIT_LOW;
            cnt   <= cnt_nxt;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_sw_debounce.sv
// Board input conditioner: debounces 5 buttons and 8 switches, adds
// per-button auto-repeat and a combined switch-change pulse.
module btn_sw_debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 200
) (
  input  logic             sys_clk_in,
  input  logic             sys_rst_n,
  input  logic [N_BTN-1:0] btn_pin,
  input  logic [N_SW-1:0]  sw_pin,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_SW-1:0]  sw_level,
  output logic             sw_change
);

  localparam int            RW   = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RW-1:0] RD_V = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RP_V = RW'(REPEAT_PERIOD);

  logic [N_SW-1:0] sw_rise, sw_fall;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
      .sys_clk_in (sys_clk_in),
      .sys_rst_n  (sys_rst_n),
      .pin        (btn_pin[i]),
      .level      (btn_level[i]),
      .rise       (btn_press[i]),
      .fall       (btn_release[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
      .sys_clk_in (sys_clk_in),
      .sys_rst_n  (sys_rst_n),
      .pin        (sw_pin[i]),
      .level      (sw_level[i]),
      .rise       (sw_rise[i]),
      .fall       (sw_fall[i])
    );
  end

  assign sw_change = |(sw_rise | sw_fall);

  // rep_cnt counts cycles since the press pulse or the last repeat tick;
  // rep_armed selects the period once the initial delay has elapsed.
  logic [RW-1:0]    rep_cnt [N_BTN];
  logic [RW-1:0]    rep_nxt [N_BTN];
  logic [N_BTN-1:0] rep_hit, rep_tick, rep_armed;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      rep_nxt[i] = btn_press[i] ? RW'(1) : rep_cnt[i] + RW'(1);
      rep_hit[i] = (rep_nxt[i] == (rep_armed[i] ? RP_V : RD_V));
    end
  end

  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N_BTN; i++) rep_cnt[i] <= '0;
      rep_tick  <= '0;
      rep_armed <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!btn_level[i]) begin
          rep_cnt[i]   <= '0;
          rep_tick[i]  <= 1'b0;
          rep_armed[i] <= 1'b0;
        end else if (rep_hit[i]) begin
          rep_cnt[i]   <= '0;
          rep_tick[i]  <= 1'b1;
          rep_armed[i] <= 1'b1;
        end else begin
          rep_cnt[i]  <= rep_nxt[i];
          rep_tick[i] <= 1'b0;
          if (btn_press[i]) rep_armed[i] <= 1'b0;
        end
      end
    end
  end

  // Gating with the level drops a tick that lands on the release edge.
  assign btn_repeat = btn_press | (rep_tick & btn_level);

endmodule
